// File: rtl/mux8_arb_pkg.sv
// rtl/mux8_arb_pkg.sv - shared types and helpers for the 8-way mux arbiter
package mux8_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [NUM_REQ-1:0] onehot(input sel_t s);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux8_1.sv
// rtl/mux8_1.sv - shared 1-bit 8:1 select datapath
module mux8_1 (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       out
);

  assign out = in[sel];

endmodule

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin search of masked requests from ptr
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  sel_t               ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic               found,
  output sel_t               idx
);

  logic [NUM_REQ-1:0] cand;
  sel_t               j;

  // Walk offsets from farthest to nearest so the nearest set bit is written last.
  always_comb begin
    cand  = req & mask;
    found = 1'b0;
    idx   = ptr;
    j     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = ptr + sel_t'(i);
      if (cand[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/mux8_arbiter.sv
// rtl/mux8_arbiter.sv - round-robin owner of mux8_1 with burst limit; ARB_PRIO0_EN gives requester 0 priority
module mux8_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] in,
  output logic [NUM_REQ-1:0] gnt,
  output sel_t               sel,
  output logic               out,
  output logic               out_valid
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_t         state, state_n;
  logic [NUM_REQ-1:0] gnt_n, pick_mask;
  sel_t               sel_n, ptr, ptr_n, rel_ptr, pick_ptr, pick_idx, win;
  logic [7:0]         cnt, cnt_n;
  logic               pick_found, rel, preempt, do_grant, mux_out;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  mux8_1 u_mux (
    .in  (in),
    .sel (sel),
    .out (mux_out)
  );

  assign out_valid = |gnt;
  assign out       = out_valid & mux_out;

  always_comb begin
    rel = !req[sel] || (cnt == HOLD_LAST);
`ifdef ARB_PRIO0_EN
    preempt = (sel != '0) && req[0];
    rel_ptr = (sel == '0) ? ptr : sel + sel_t'(1);
`else
    preempt = 1'b0;
    rel_ptr = sel + sel_t'(1);
`endif
    // While busy the releasing owner is masked out; it only wins back as a fallback.
    pick_ptr  = (state == BUSY) ? rel_ptr : ptr;
    pick_mask = (state == BUSY) ? ~onehot(sel) : '1;
  end

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    sel_n    = sel;
    ptr_n    = ptr;
    cnt_n    = cnt;
    do_grant = 1'b0;
    win      = pick_idx;
    if (state == IDLE) begin
`ifdef ARB_PRIO0_EN
      if (req[0]) begin
        do_grant = 1'b1;
        win      = '0;
      end else if (pick_found) begin
        do_grant = 1'b1;
      end
`else
      if (pick_found) do_grant = 1'b1;
`endif
    end else if (preempt) begin
      ptr_n    = sel + sel_t'(1);
      do_grant = 1'b1;
      win      = '0;
    end else if (rel) begin
      ptr_n = rel_ptr;
      if (pick_found) begin
        do_grant = 1'b1;
      end else if (req[sel]) begin
        do_grant = 1'b1;
        win      = sel;
      end else begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    end else begin
      cnt_n = cnt + 8'd1;
    end
    if (do_grant) begin
      state_n = BUSY;
      sel_n   = win;
      gnt_n   = onehot(win);
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_mux8_arbiter.sv
// tb/tb_mux8_arbiter.sv - self-checking bench for mux8_arbiter against an ownership model
module tb_mux8_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] req_v, din;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       out, out_valid;

  int tests_run = 0;
  int tests_failed = 0;

  int m_owner, m_ptr, m_held, m_sel;

  mux8_arbiter #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_v),
    .in        (din),
    .gnt       (gnt),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_sel   = 0;
  endtask

  task automatic model_grant(input int w);
    m_owner = w;
    m_sel   = w;
    m_held  = 1;
  endtask

  // Ownership model: m_held counts cycles the current owner has held the grant.
  task automatic model_step();
    int start, nw, idx;
    if (m_owner < 0) begin
      nw = -1;
`ifdef ARB_PRIO0_EN
      if (req_v[0]) nw = 0;
`endif
      for (int k = 0; k < 8; k++) begin
        idx = (m_ptr + k) % 8;
        if (nw < 0 && req_v[idx]) nw = idx;
      end
      if (nw >= 0) model_grant(nw);
    end else begin
`ifdef ARB_PRIO0_EN
      if (m_owner != 0 && req_v[0]) begin
        m_ptr = (m_owner + 1) % 8;
        model_grant(0);
        return;
      end
`endif
      if (req_v[m_owner] && m_held < MH) begin
        m_held++;
      end else begin
        start = (m_owner + 1) % 8;
`ifdef ARB_PRIO0_EN
        if (m_owner == 0) start = m_ptr;
`endif
        m_ptr = start;
        nw = -1;
        for (int k = 0; k < 8; k++) begin
          idx = (start + k) % 8;
          if (nw < 0 && idx != m_owner && req_v[idx]) nw = idx;
        end
        if (nw < 0 && req_v[m_owner]) nw = m_owner;
        if (nw >= 0) model_grant(nw);
        else         m_owner = -1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    check({tag, ".gnt"}, 32'(gnt), 32'(eg));
    check({tag, ".sel"}, 32'(sel), 32'(m_sel));
    check({tag, ".valid"}, 32'(out_valid), 32'(m_owner >= 0));
    check({tag, ".out"}, 32'(out), (m_owner >= 0) ? 32'(din[m_owner]) : 32'd0);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    req_v   = 8'hFF;
    din     = 8'hA5;
    model_reset();

    // Reset with all requesting
    @(negedge clk);
    @(negedge clk);
    check("rst.gnt", 32'(gnt), 32'h0);
    check("rst.sel", 32'(sel), 32'h0);
    check("rst.valid", 32'(out_valid), 32'h0);
    check("rst.out", 32'(out), 32'h0);
    reset_n = 1'b1;
    tick("rst_rel");
    check("rst_rel.first", 32'(gnt), 32'h01);

    // Rotation with wrap 7 -> 0
    for (int c = 0; c < 34; c++) begin
      din = 8'($urandom);
      tick("rot");
    end
    check("rot.wrap_owner", 32'(gnt), 32'h01);

    // Single requester regranted after expiry
    do_reset();
    req_v = 8'h20;
    for (int c = 0; c < 10; c++) begin
      din = 8'($urandom);
      tick("single");
    end
    check("single.hold", 32'(gnt), 32'h20);

    // Early drop by owner 3 while 6 is waiting
    do_reset();
    req_v = 8'h08;
    tick("drop.a");
    tick("drop.b");
    req_v = 8'h40;
    tick("drop.c");
    check("drop.to6", 32'(gnt), 32'h40);
    req_v = 8'h00;
    tick("drop.d");
    req_v = 8'h50;
    tick("drop.e");
    check("drop.ptr4", 32'(gnt), 32'h10);

    // Release to idle
    do_reset();
    req_v = 8'h02;
    tick("idle.a");
    tick("idle.b");
    req_v = 8'h00;
    tick("idle.c");
    check("idle.gnt", 32'(gnt), 32'h0);

    // Asynchronous reset mid-burst
    req_v = 8'hFF;
    tick("arst.a");
    tick("arst.b");
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("arst.gnt", 32'(gnt), 32'h0);
    check("arst.valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef ARB_PRIO0_EN
    do_reset();
    req_v = 8'h20;
    tick("prio.a");
    tick("prio.b");
    req_v = 8'h21;
    tick("prio.c");
    check("prio.preempt", 32'(gnt), 32'h01);
    req_v = 8'hE0;
    tick("prio.d");
    check("prio.after0", 32'(gnt), 32'h40);
`endif

    // Randomized traffic with occasional resets
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req_v = 8'($urandom);
      else if ($urandom_range(0, 3) == 0) req_v = 8'($urandom) & 8'($urandom);
      din = 8'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
